// File: rtl/upc_loop_monitor_pkg.sv
// rtl/upc_loop_monitor_pkg.sv - shared types and defaults for the HLS loop monitor
package upc_loop_monitor_pkg;

    localparam int UPC_CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_CONT = 2'd2
    } upc_state_e;

endpackage

// File: rtl/upc_sat_counter.sv
// rtl/upc_sat_counter.sv - saturating counter with clear, load and freeze enable
module upc_sat_counter
    import upc_loop_monitor_pkg::*;
#(
    parameter int W = UPC_CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // i_en low holds the value; clear beats load beats increment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_count <= '0;
            end else if (i_load) begin
                r_count <= i_load_val;
            end else if (i_inc && !(&r_count)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/upc_loop_monitor.sv
// rtl/upc_loop_monitor.sv - passive invocation/iteration/latency monitor for one HLS pipelined loop
// Optional stall counter: define UPC_LOOP_MONITOR_STALL_EN.
module upc_loop_monitor
    import upc_loop_monitor_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = UPC_CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic               busy,
    output logic [CNT_W-1:0]   loop_count,
    output logic [CNT_W-1:0]   iter_started,
    output logic [CNT_W-1:0]   iter_ended,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               err,
    output logic               summary_valid
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    upc_state_e     r_state;
    logic           r_busy;
    logic           r_err;
    logic           r_summary_valid;

    logic             w_run;
    logic             w_start_ev;
    logic             w_end_ev;
    logic             w_quit_ev;
    logic             w_accept;
    logic             w_complete;
    logic             w_err_set;
    logic             w_infl_chg;
    logic [CNT_W-1:0] w_inflight;
    logic [CNT_W-1:0] w_infl_next;
    logic [CNT_W-1:0] w_lat_run;
    logic [CNT_W-1:0] w_lat_now;
    logic             w_unused_ready;

    assign w_unused_ready = loop_ready;
    assign w_run          = !r_summary_valid;

    assign w_start_ev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    assign w_end_ev   = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    assign w_quit_ev  = (cur_state == quit_state) && quit_enable && !quit_block;

    // A start taken in IDLE together with done is a one-cycle invocation
    assign w_accept   = loop_start && ((r_state == IDLE) ||
                        ((r_state == ACTIVE) && loop_done && loop_continue));
    assign w_complete = loop_done && ((r_state == ACTIVE) || ((r_state == IDLE) && loop_start));

    assign w_lat_now = (r_state != ACTIVE) ? ONE :
                       (&w_lat_run)        ? w_lat_run : w_lat_run + 1'b1;

    assign w_infl_chg  = w_start_ev ^ w_end_ev;
    assign w_infl_next = w_start_ev ? ((&w_inflight) ? w_inflight : w_inflight + 1'b1)
                                    : ((w_inflight == '0) ? w_inflight : w_inflight - 1'b1);

    assign w_err_set = (w_end_ev && (w_inflight == '0)) ||
                       (w_complete && quit_at_end && (w_inflight != '0) && !w_quit_ev) ||
                       (loop_done && (r_state == IDLE) && !loop_start);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
            r_summary_valid <= 1'b0;
        end else if (w_run) begin
            r_summary_valid <= finish;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (loop_start && loop_done && loop_continue) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (loop_start && loop_done) begin
                        r_state <= WAIT_CONT;
                        r_busy  <= 1'b1;
                    end else if (loop_start) begin
                        r_state <= ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (loop_done && loop_continue && !loop_start) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (loop_done && !loop_continue) begin
                        r_state <= WAIT_CONT;
                    end
                end
                WAIT_CONT: begin
                    if (loop_continue) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    upc_sat_counter #(.W(CNT_W)) u_loop_cnt (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(1'b0), .i_load_val('0), .i_inc(w_complete), .o_count(loop_count)
    );

    upc_sat_counter #(.W(CNT_W)) u_iter_start (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(1'b0), .i_load_val('0), .i_inc(w_start_ev), .o_count(iter_started)
    );

    upc_sat_counter #(.W(CNT_W)) u_iter_end (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(1'b0), .i_load_val('0), .i_inc(w_end_ev), .o_count(iter_ended)
    );

    upc_sat_counter #(.W(CNT_W)) u_inflight (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(w_complete),
        .i_load(w_infl_chg), .i_load_val(w_infl_next), .i_inc(1'b0), .o_count(w_inflight)
    );

    // Running latency: restarts at 1 whenever a start is accepted
    upc_sat_counter #(.W(CNT_W)) u_lat_run (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(w_accept), .i_load_val(ONE), .i_inc(r_state == ACTIVE), .o_count(w_lat_run)
    );

    upc_sat_counter #(.W(CNT_W)) u_last_lat (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(w_complete), .i_load_val(w_lat_now), .i_inc(1'b0), .o_count(last_latency)
    );

`ifdef UPC_LOOP_MONITOR_STALL_EN
    upc_sat_counter #(.W(CNT_W)) u_stall (
        .i_clk(clock), .i_rst(reset), .i_en(w_run), .i_clr(1'b0),
        .i_load(1'b0), .i_load_val('0), .i_inc((r_state != IDLE) && iter_start_block),
        .o_count(stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

    assign busy          = r_busy;
    assign err           = r_err;
    assign summary_valid = r_summary_valid;

endmodule

// File: tb/tb_upc_loop_monitor.sv
// tb/tb_upc_loop_monitor.sv - vector table plus scoreboard bench for upc_loop_monitor
module tb_upc_loop_monitor;

`ifdef UPC_LOOP_MONITOR_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam logic [10:0] I_RST = 11'h001, I_LS  = 11'h002, I_LD  = 11'h004, I_LC  = 11'h008;
    localparam logic [10:0] I_SE  = 11'h010, I_EE  = 11'h020, I_BLK = 11'h040, I_FIN = 11'h080;
    localparam logic [10:0] I_QAE = 11'h100, I_QEN = 11'h200, I_CS1 = 11'h400;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;
    logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic       iter_start_block, iter_end_block, quit_block;
    logic       iter_start_enable, iter_end_enable, quit_enable;

    logic        busy, err, summary_valid;
    logic [31:0] loop_count, iter_started, iter_ended, last_latency, stall_cycles;
    logic        busy4, err4, summary_valid4;
    logic [3:0]  loop_count4, iter_started4, iter_ended4, last_latency4, stall_cycles4;

    upc_loop_monitor u_dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
        .busy(busy), .loop_count(loop_count), .iter_started(iter_started), .iter_ended(iter_ended),
        .last_latency(last_latency), .stall_cycles(stall_cycles), .err(err), .summary_valid(summary_valid)
    );

    upc_loop_monitor #(.CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
        .busy(busy4), .loop_count(loop_count4), .iter_started(iter_started4), .iter_ended(iter_ended4),
        .last_latency(last_latency4), .stall_cycles(stall_cycles4), .err(err4), .summary_valid(summary_valid4)
    );

    typedef struct {
        logic [10:0] in;
        string       nm;
        logic        busy;
        int          lcnt, ist, ien, lat, stall;
        logic        err, sv;
        bit          c4;
        int          ist4;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic e_busy, e_err, e_sv;
    int   e_lcnt, e_ist, e_ien, e_lat, e_stall, e_ist4;

    task automatic e_clear();
        e_busy = 0; e_err = 0; e_sv = 0;
        e_lcnt = 0; e_ist = 0; e_ien = 0; e_lat = 0; e_stall = 0; e_ist4 = 0;
    endtask

    function automatic vec_t snap(input logic [10:0] in, input string nm, input bit c4);
        vec_t v;
        v.in = in; v.nm = nm; v.busy = e_busy; v.lcnt = e_lcnt; v.ist = e_ist; v.ien = e_ien;
        v.lat = e_lat; v.stall = e_stall; v.err = e_err; v.sv = e_sv; v.c4 = c4; v.ist4 = e_ist4;
        return v;
    endfunction

    task automatic add(input logic [10:0] in, input string nm);
        tbl.push_back(snap(in, nm, 1'b0));
    endtask

    task automatic apply(input logic [10:0] in);
        reset             = in[0];
        loop_start        = in[1];
        loop_done         = in[2];
        loop_ready        = in[2];
        loop_continue     = in[3];
        iter_start_enable = in[4];
        iter_end_enable   = in[5];
        iter_start_block  = in[6];
        finish            = in[7];
        quit_at_end       = in[8];
        quit_enable       = in[9];
        cur_state         = in[10];
    endtask

    task automatic cmp(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0d expected %0d", nm, f, act, exp);
        end
    endtask

    // Push the expectation with the stimulus, pop and compare once the edge has registered it
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clock);
        apply(v.in);
        sb_q.push_back(v);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        cmp(e.nm, "busy",          64'(busy),          64'(e.busy));
        cmp(e.nm, "loop_count",    64'(loop_count),    64'(e.lcnt));
        cmp(e.nm, "iter_started",  64'(iter_started),  64'(e.ist));
        cmp(e.nm, "iter_ended",    64'(iter_ended),    64'(e.ien));
        cmp(e.nm, "last_latency",  64'(last_latency),  64'(e.lat));
        cmp(e.nm, "stall_cycles",  64'(stall_cycles),  64'(e.stall));
        cmp(e.nm, "err",           64'(err),           64'(e.err));
        cmp(e.nm, "summary_valid", 64'(summary_valid), 64'(e.sv));
        if (e.c4) begin
            cmp(e.nm, "w4.iter_started",  64'(iter_started4),  64'(e.ist4));
            cmp(e.nm, "w4.summary_valid", 64'(summary_valid4), 64'(e.sv));
        end
    endtask

    initial begin
        iter_start_state = 1'b0; iter_end_state = 1'b0; quit_state = 1'b0;
        iter_end_block = 1'b0; quit_block = 1'b0;
        apply(I_RST);

        // 4-iteration invocation, start to done spans 6 cycles
        e_clear();                                   add(I_RST, "reset");
        e_busy = 1;                                  add(I_LS, "start1");
        e_ist = 1;                                   add(I_SE, "it1");
        e_ist = 2; e_ien = 1;                        add(I_SE | I_EE, "it2");
        e_ist = 3; e_ien = 2;                        add(I_SE | I_EE, "it3");
        e_ist = 4; e_ien = 3;                        add(I_SE | I_EE, "it4");
        e_ien = 4; e_lcnt = 1; e_lat = 6; e_busy = 0; add(I_EE | I_LD | I_LC, "done1");
                                                     add(I_CS1 | I_SE, "state_mismatch");
        // done held without continue
        e_busy = 1;                                  add(I_LS, "start2");
        e_lcnt = 2; e_lat = 2;                       add(I_LD, "wait_c0");
                                                     add(I_LD, "wait_c1");
                                                     add(I_LD, "wait_c2");
        e_busy = 0;                                  add(I_LD | I_LC, "cont");
        // back-to-back
        e_busy = 1;                                  add(I_LS, "b2b_s");
                                                     add('0, "b2b_w");
        e_lcnt = 3; e_lat = 3;                       add(I_LS | I_LD | I_LC, "b2b_join");
                                                     add('0, "b2b_w2");
                                                     add('0, "b2b_w3");
        e_lcnt = 4; e_lat = 4; e_busy = 0;           add(I_LD | I_LC, "b2b_done");
        // stall: block while idle must not count
        e_busy = 1;                                  add(I_LS | I_BLK, "st_start");
        e_stall = STALL_EN ? 1 : 0;                  add(I_SE | I_BLK, "stall1");
        e_stall = STALL_EN ? 2 : 0;                  add(I_SE | I_BLK, "stall2");
        e_stall = STALL_EN ? 3 : 0;                  add(I_SE | I_BLK, "stall3");
        e_lcnt = 5; e_lat = 5; e_busy = 0;           add(I_LD | I_LC, "st_done");
                                                     add(I_BLK, "blk_idle");
        // protocol errors
        e_ien = 5; e_err = 1;                        add(I_EE, "end_no_start");
        e_busy = 1;                                  add(I_LS, "clean_s");
        e_ist = 5;                                   add(I_SE, "clean_it");
        e_ien = 6; e_lcnt = 6; e_lat = 3; e_busy = 0; add(I_EE | I_LD | I_LC, "clean_done");
        e_clear();                                   add(I_RST, "reset2");
        e_err = 1;                                   add(I_LD, "done_idle");
        e_clear();                                   add(I_RST, "reset3");
        // quit_at_end with and without a quit event
        e_busy = 1;                                  add(I_LS, "q_s1");
        e_ist = 1;                                   add(I_SE, "q_it1");
        e_lcnt = 1; e_lat = 3; e_busy = 0;           add(I_LD | I_LC | I_QAE | I_QEN, "q_done_ok");
        e_busy = 1;                                  add(I_LS, "q_s2");
        e_ist = 2;                                   add(I_SE, "q_it2");
        e_lcnt = 2; e_err = 1; e_busy = 0;           add(I_LD | I_LC | I_QAE, "q_done_bad");
        e_clear();                                   add(I_RST, "reset4");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // saturation at CNT_W=4, then freeze
        e_clear();
        for (int i = 1; i <= 20; i++) begin
            e_ist  = i;
            e_ist4 = (i > 15) ? 15 : i;
            step(snap(I_SE, $sformatf("sat%0d", i), 1'b1));
        end
        e_sv = 1;
        step(snap(I_FIN, "finish", 1'b1));
        step(snap(I_LS | I_SE | I_EE | I_LD | I_LC, "frozen_all", 1'b1));
        step(snap(I_SE | I_BLK, "frozen_blk", 1'b1));
        step(snap(I_EE, "frozen_end", 1'b1));
        step(snap(I_LD, "frozen_done", 1'b1));
        e_clear();
        step(snap(I_RST, "unfreeze", 1'b1));

        cmp("scoreboard", "leftover", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
